johnson_seq_gen: RTL

Parametrised Johnson (twisted-ring) sequence generator, successor to the fixed 8-bit Johnson counter. Adds configurable width, enable, up/down direction, parallel load, binary phase index and one-hot phase decode, a wrap pulse, and optional self-correction of illegal states. It is the phase/timing source for sequencers and multi-phase strobe generation.

---
 rtl/johnson_pkg.sv | 46 ++++
 rtl/johnson_seq_gen_decode.sv | 25 ++
 rtl/johnson_seq_gen.sv | 55 +++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Width-generic helpers for Johnson (twisted-ring) codes.
// Vectors are zero-extended to JC_MAXW bits; only the low w bits are meaningful.
package johnson_pkg;

  localparam int JC_MAXW = 32;

  typedef logic [JC_MAXW-1:0] jc_vec_t;

  // A legal code has at most one boundary between adjacent bits.
  function automatic logic jc_is_legal(jc_vec_t vec, int w);
    int n = 0;
    for (int i = 0; i < JC_MAXW - 1; i++) begin
      if (i < w - 1 && vec[i] != vec[i+1]) n++;
    end
    return (n <= 1);
  endfunction

  function automatic int jc_phase(jc_vec_t vec, int w);
    int pc = 0;
    for (int i = 0; i < JC_MAXW; i++) begin
      if (i < w && vec[i]) pc++;
    end
    if (vec[0]) return pc;
    else if (pc == 0) return 0;
    else return 2 * w - pc;
  endfunction

  function automatic jc_vec_t jc_up(jc_vec_t vec, int w);
    jc_vec_t r = '0;
    for (int i = 1; i < JC_MAXW; i++) begin
      if (i < w) r[i] = vec[i-1];
    end
    r[0] = ~vec[w-1];
    return r;
  endfunction

  function automatic jc_vec_t jc_down(jc_vec_t vec, int w);
    jc_vec_t r = '0;
    for (int i = 0; i < JC_MAXW - 1; i++) begin
      if (i < w - 1) r[i] = vec[i+1];
    end
    r[w-1] = ~vec[0];
    return r;
  endfunction

endpackage

// File: rtl/johnson_seq_gen_decode.sv
// Combinational decode of a Johnson register into phase index, one-hot phase
// and legality; illegal codes report phase 0 and an all-zero one-hot.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   out,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] dec,
  output logic               legal
);

  always_comb begin
    legal = jc_is_legal(JC_MAXW'(out), WIDTH);
    phase = '0;
    dec   = '0;
    if (legal) begin
      phase      = PW'(jc_phase(JC_MAXW'(out), WIDTH));
      dec[phase] = 1'b1;
    end
  end

endmodule

// File: rtl/johnson_seq_gen.sv
// Parametrised Johnson sequence generator: up/down stepping, parallel load,
// wrap pulse and optional recovery of illegal states to phase 0.
module johnson_seq_gen
  import johnson_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SELF_CORRECT = 1,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   out,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] dec,
  output logic               legal,
  output logic               wrap,
  output logic               err
);

  localparam logic [PW-1:0] PH_LAST = PW'(2 * WIDTH - 1);

  johnson_phase_decode #(.WIDTH(WIDTH)) u_decode (
    .out   (out),
    .phase (phase),
    .dec   (dec),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out  <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (load) begin
        out <= load_val;
      end else if (SELF_CORRECT != 0 && !legal) begin
        out <= '0;
        err <= 1'b1;
      end else if (en) begin
        if (dir) out <= WIDTH'(jc_down(JC_MAXW'(out), WIDTH));
        else     out <= WIDTH'(jc_up(JC_MAXW'(out), WIDTH));
        // phase reads 0 for illegal codes, so gate wrap on legality too
        wrap <= legal && ((!dir && phase == PH_LAST) || (dir && phase == '0));
      end
    end
  end

endmodule
